// File: rtl/control_unit_if.sv
// ============================================================================
// control_unit_if : instruction-field, ALU-flag and datapath-control bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface control_unit_if;
  logic [5:0] OPCODE;
  logic [5:0] FUNCT;
  logic       Overflow;
  logic       Zero;
  logic       Igual;

  logic       PCwrite;
  logic       MemWrite;
  logic       MemRead;
  logic       IRWrite;
  logic       RegWrite;
  logic       EPCWrite;
  logic       IorD;
  logic       AluSrcA;
  logic       MemToReg;
  logic       RegDest;
  logic       ExcpSel;
  logic [3:0] AluSrcB;
  logic [2:0] ALUControl;
  logic [2:0] ShiftControl;
  logic [1:0] PCSource;
  logic [4:0] state;

  modport master (
    input  OPCODE, FUNCT, Overflow, Zero, Igual,
    output PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, IorD,
           AluSrcA, MemToReg, RegDest, ExcpSel, AluSrcB, ALUControl,
           ShiftControl, PCSource, state
  );

  modport slave (
    output OPCODE, FUNCT, Overflow, Zero, Igual,
    input  PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, IorD,
           AluSrcA, MemToReg, RegDest, ExcpSel, AluSrcB, ALUControl,
           ShiftControl, PCSource, state
  );
endinterface

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// control_unit : multicycle main-control FSM (fetch/decode/exec/mem/wb + traps)
// Optional: CU_OVERFLOW_EXCP_EN traps add/sub/addi overflow.   Rev 1.0
// ============================================================================
`default_nettype none

module control_unit (
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master bus
);

  localparam logic [4:0] S_RESET     = 5'd0;
  localparam logic [4:0] S_FETCH0    = 5'd1;
  localparam logic [4:0] S_FETCH1    = 5'd2;
  localparam logic [4:0] S_FETCH2    = 5'd3;
  localparam logic [4:0] S_DECODE    = 5'd4;
  localparam logic [4:0] S_RT_EXEC   = 5'd5;
  localparam logic [4:0] S_RT_WB     = 5'd6;
  localparam logic [4:0] S_SH_LOAD   = 5'd7;
  localparam logic [4:0] S_SH_DO     = 5'd8;
  localparam logic [4:0] S_SH_WB     = 5'd9;
  localparam logic [4:0] S_JR        = 5'd10;
  localparam logic [4:0] S_ADDI_EXEC = 5'd11;
  localparam logic [4:0] S_ADDI_WB   = 5'd12;
  localparam logic [4:0] S_MEM_ADDR  = 5'd13;
  localparam logic [4:0] S_LW_RD     = 5'd14;
  localparam logic [4:0] S_LW_WAIT   = 5'd15;
  localparam logic [4:0] S_LW_WB     = 5'd16;
  localparam logic [4:0] S_SW_WR     = 5'd17;
  localparam logic [4:0] S_BRANCH    = 5'd18;
  localparam logic [4:0] S_JUMP      = 5'd19;
  localparam logic [4:0] S_JAL       = 5'd20;
  localparam logic [4:0] S_EXCP_SAVE = 5'd21;
  localparam logic [4:0] S_EXCP_RD   = 5'd22;
  localparam logic [4:0] S_EXCP_WAIT = 5'd23;
  localparam logic [4:0] S_EXCP_JUMP = 5'd24;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_CMP  = 3'b111;

  localparam logic [2:0] SH_LOAD = 3'b001;
  localparam logic [2:0] SH_SLL  = 3'b010;
  localparam logic [2:0] SH_SRL  = 3'b011;
  localparam logic [2:0] SH_SRA  = 3'b100;

  logic [4:0] state_q, state_d;
  logic       excp_q, excp_d;
  logic       ovf_trap;
  logic       unused_flags;
  logic       rt_arith;

`ifdef CU_OVERFLOW_EXCP_EN
  assign ovf_trap     = bus.Overflow;
  assign unused_flags = bus.Zero;
`else
  assign ovf_trap     = 1'b0;
  assign unused_flags = bus.Zero ^ bus.Overflow;
`endif

  // Only add/sub can overflow among the R-type ALU operations.
  assign rt_arith = (bus.FUNCT == FN_ADD) || (bus.FUNCT == FN_SUB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      excp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      excp_q  <= excp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    excp_d  = excp_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH0;
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        excp_d  = 1'b0;
        state_d = S_EXCP_SAVE;
        case (bus.OPCODE)
          OP_RTYPE: begin
            case (bus.FUNCT)
              FN_ADD, FN_SUB, FN_AND: state_d = S_RT_EXEC;
              FN_SLL, FN_SRL, FN_SRA: state_d = S_SH_LOAD;
              FN_JR:                  state_d = S_JR;
              default:                state_d = S_EXCP_SAVE;
            endcase
          end
          OP_ADDI:       state_d = S_ADDI_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_JAL:        state_d = S_JAL;
          default:       state_d = S_EXCP_SAVE;
        endcase
      end
      S_RT_EXEC: begin
        if (ovf_trap && rt_arith) begin
          state_d = S_EXCP_SAVE;
          excp_d  = 1'b1;
        end else begin
          state_d = S_RT_WB;
        end
      end
      S_ADDI_EXEC: begin
        if (ovf_trap) begin
          state_d = S_EXCP_SAVE;
          excp_d  = 1'b1;
        end else begin
          state_d = S_ADDI_WB;
        end
      end
      S_SH_LOAD:   state_d = S_SH_DO;
      S_SH_DO:     state_d = S_SH_WB;
      S_MEM_ADDR:  state_d = (bus.OPCODE == OP_LW) ? S_LW_RD : S_SW_WR;
      S_LW_RD:     state_d = S_LW_WAIT;
      S_LW_WAIT:   state_d = S_LW_WB;
      S_JAL:       state_d = S_JUMP;
      S_EXCP_SAVE: state_d = S_EXCP_RD;
      S_EXCP_RD:   state_d = S_EXCP_WAIT;
      S_EXCP_WAIT: state_d = S_EXCP_JUMP;
      S_RT_WB, S_ADDI_WB, S_LW_WB, S_SH_WB, S_SW_WR,
      S_BRANCH, S_JUMP, S_JR, S_EXCP_JUMP: state_d = S_FETCH0;
      default:     state_d = S_RESET;
    endcase
  end

  // Outputs are forced low while reset is held so no write can slip through.
  always_comb begin
    bus.PCwrite      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.MemRead      = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.EPCWrite     = 1'b0;
    bus.IorD         = 1'b0;
    bus.AluSrcA      = 1'b0;
    bus.MemToReg     = 1'b0;
    bus.RegDest      = 1'b0;
    bus.ExcpSel      = 1'b0;
    bus.AluSrcB      = 4'd0;
    bus.ALUControl   = ALU_PASS;
    bus.ShiftControl = 3'b000;
    bus.PCSource     = 2'b00;
    bus.state        = state_q;
    if (reset) begin
      case (state_q)
        S_RESET: begin
          bus.RegWrite = 1'b1;
          bus.RegDest  = 1'b1;
        end
        S_FETCH0, S_FETCH1: begin
          bus.AluSrcB    = 4'd1;
          bus.ALUControl = ALU_ADD;
        end
        S_FETCH2: begin
          bus.IRWrite    = 1'b1;
          bus.PCwrite    = 1'b1;
          bus.AluSrcB    = 4'd1;
          bus.ALUControl = ALU_ADD;
        end
        S_DECODE: begin
          bus.AluSrcB    = 4'd3;
          bus.ALUControl = ALU_ADD;
        end
        S_RT_EXEC: begin
          bus.AluSrcA = 1'b1;
          case (bus.FUNCT)
            FN_SUB:  bus.ALUControl = ALU_SUB;
            FN_AND:  bus.ALUControl = ALU_AND;
            default: bus.ALUControl = ALU_ADD;
          endcase
        end
        S_RT_WB, S_SH_WB: begin
          bus.RegWrite = 1'b1;
          bus.RegDest  = 1'b1;
        end
        S_SH_LOAD: bus.ShiftControl = SH_LOAD;
        S_SH_DO: begin
          case (bus.FUNCT)
            FN_SRL:  bus.ShiftControl = SH_SRL;
            FN_SRA:  bus.ShiftControl = SH_SRA;
            default: bus.ShiftControl = SH_SLL;
          endcase
        end
        S_JR: begin
          bus.AluSrcA = 1'b1;
          bus.PCwrite = 1'b1;
        end
        S_ADDI_EXEC, S_MEM_ADDR: begin
          bus.AluSrcA    = 1'b1;
          bus.AluSrcB    = 4'd2;
          bus.ALUControl = ALU_ADD;
        end
        S_ADDI_WB: bus.RegWrite = 1'b1;
        S_LW_RD:   bus.IorD     = 1'b1;
        S_LW_WAIT: bus.MemRead  = 1'b1;
        S_LW_WB: begin
          bus.RegWrite = 1'b1;
          bus.MemToReg = 1'b1;
        end
        S_SW_WR: begin
          bus.IorD     = 1'b1;
          bus.MemWrite = 1'b1;
        end
        S_BRANCH: begin
          bus.AluSrcA    = 1'b1;
          bus.ALUControl = ALU_CMP;
          bus.PCSource   = 2'b01;
          bus.PCwrite    = (bus.OPCODE == OP_BEQ) ? bus.Igual : ~bus.Igual;
        end
        S_JUMP: begin
          bus.PCSource = 2'b10;
          bus.PCwrite  = 1'b1;
        end
        S_JAL: bus.RegWrite = 1'b1;
        S_EXCP_SAVE: begin
          bus.AluSrcB    = 4'd1;
          bus.ALUControl = ALU_SUB;
          bus.EPCWrite   = 1'b1;
          bus.ExcpSel    = excp_q;
        end
        S_EXCP_RD: begin
          bus.IorD    = 1'b1;
          bus.ExcpSel = excp_q;
        end
        S_EXCP_WAIT: begin
          bus.MemRead = 1'b1;
          bus.ExcpSel = excp_q;
        end
        S_EXCP_JUMP: begin
          bus.PCSource = 2'b11;
          bus.PCwrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/control_unit.md
# control_unit

Multicycle main-control FSM for the CPU datapath. It reads the instruction fields latched in the instruction register and the ALU status flags, and drives every datapath control wire: PC, memory, IR, register bank, ALU, shifter, the A/B source muxes, EPC and the exception-address mux. It implements fetch, decode, execute, memory and write-back sequencing, plus opcode and overflow exceptions.

## Interface
- No parameters; all encodings are fixed below.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; forces state RESET.
- OPCODE  in  6  IR[31:26].
- FUNCT  in  6  IR[5:0].
- Overflow, Zero, Igual  in  1 each  ALU flags, combinational from the current ALU inputs.
- PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, IorD, AluSrcA, MemToReg, RegDest, ExcpSel  out  1 each  datapath enables and selects.
- AluSrcB  out  4  0=B, 1=const 4, 2=SignExt, 3=ShiftL2; other values unused.
- ALUControl  out  3  000 pass A, 001 add, 010 sub, 011 and, 111 compare.
- ShiftControl  out  3  000 hold, 001 load, 010 sll, 011 srl, 100 sra.
- PCSource  out  2  00 ALUResult, 01 ALUout, 10 jump target, 11 MemRegout (exception vector).
- state  out  5  current state, for debug.

## Operation
- Moore outputs, decoded from `state` only. All outputs are 0 in every state unless listed for that state.
- RESET:
  - One cycle with RegWrite=1, RegDest=1 and the WriteData path selecting the constant 227, which loads $29.
  - Then go to FETCH0.
- FETCH0/FETCH1 (memory wait): IorD=0, AluSrcA=0, AluSrcB=1, ALUControl=add.
- FETCH2: IRWrite=1, PCwrite=1, PCSource=00, so PC gets PC+4.
- DECODE: AluSrcA=0, AluSrcB=3, ALUControl=add; ALUout gets the branch target. Dispatch on OPCODE/FUNCT:
  - R-type 0x00:
    - FUNCT 0x20 add → RT_EXEC with ALUControl=add.
    - FUNCT 0x22 sub → RT_EXEC with ALUControl=sub.
    - FUNCT 0x24 and → RT_EXEC with ALUControl=and.
    - FUNCT 0x00/0x02/0x03 sll/srl/sra → SH_LOAD, SH_DO, SH_WB.
    - FUNCT 0x08 jr → JR (PCSource=00, ALU pass A, PCwrite).
  - Immediates and memory:
    - 0x08 addi → ADDI_EXEC, ADDI_WB.
    - 0x23 lw → MEM_ADDR, LW_RD, LW_WAIT, LW_WB.
    - 0x2B sw → MEM_ADDR, SW_WR.
  - Control flow:
    - 0x04 beq / 0x05 bne → BRANCH: ALU compare A,B; PCwrite = Igual (beq) or !Igual (bne); PCSource=01.
    - 0x02 j → JUMP: PCSource=10, PCwrite.
    - 0x03 jal → JAL: write PC into $31, then PCwrite with target.
  - Any other opcode or funct → EXCP_SAVE with ExcpSel=0.
- Write-back states (RT_WB, ADDI_WB, LW_WB, SH_WB) return to FETCH0. So do SW_WR, BRANCH, JUMP, JR and EXCP_JUMP.
- Exception sequence:
  - EXCP_SAVE: ALU computes PC-4 (AluSrcA=0, AluSrcB=1, sub); EPCWrite=1.
  - EXCP_RD: IorD=1, reading vector byte 253 (ExcpSel=0) or 254 (ExcpSel=1).
  - EXCP_WAIT: MemRead=1.
  - EXCP_JUMP: PCSource=11, PCwrite=1.

## Timing
- Instruction cycle counts, including the 3 fetch cycles:
  - add/sub/and/addi = 6.
  - shifts = 7.
  - lw = 8.
  - sw = 6.
  - beq/bne/j/jr = 5.
  - jal = 6.
  - exceptions = 8 from DECODE entry.
- RT_EXEC and ADDI_EXEC are where Overflow is sampled. If Overflow=1 and the feature is enabled, go to EXCP_SAVE with ExcpSel=1 and do not assert RegWrite.
- Reset may be asserted at any cycle. It clears state to RESET immediately and drives all outputs to 0 while held. No partial write completes after reset falls.
- ExcpSel is held through EXCP_RD and EXCP_WAIT.

## Configuration
- `CU_OVERFLOW_EXCP_EN` defined: overflow on add/sub/addi traps as described; the destination register is not written.
- `CU_OVERFLOW_EXCP_EN` undefined: Overflow is ignored, the wrapped result is written, and ExcpSel is only ever 0.

## Test plan
- Reset: hold reset=0 for 3 cycles, then release → state=RESET for one cycle, then FETCH0; PCwrite=1 exactly at FETCH2 (cycle 3 after RESET).
- add $3,$1,$2 with FUNCT 0x20 → FETCH0..RT_WB in 6 cycles; RegWrite=1 only in RT_WB with RegDest=1.
- beq, Igual=1 → PCwrite=1 with PCSource=01 in BRANCH. Same with Igual=0 → PCwrite=0.
- lw → IorD=1 in LW_RD; MemRead=1 in LW_WAIT; RegWrite and MemToReg=1 in LW_WB; 8 cycles total.
- OPCODE 0x3F → EPCWrite=1 in EXCP_SAVE; ExcpSel=0; PCSource=11 with PCwrite in EXCP_JUMP.
- add with Overflow=1: with the macro defined → ExcpSel=1 path and no RegWrite; undefined → RT_WB with RegWrite=1.
